ascii_hex_parser: RTL and testbench
===================================

// Module: ascii_hex_parser
//
// PURPOSE
// Streaming parser turning ASCII hex text into binary words. Consumes one char
// per cycle over valid/ready, accumulates hex digits MSB-first, emits one word
// per delimiter-terminated token with digit count and error flag. Sits after
// UART RX / debug console, feeding register-write or command decoders.
//
// PARAMETERS
// DIGITS        8  max hex digits per token; output width W = 4*DIGITS
// ALLOW_PREFIX  1  1: optional leading "0x"/"0X" accepted and discarded
// ALLOW_LOWER   1  1: 'a'..'f' accepted as digits; 0: lowercase is invalid
//
// PORTS
// clk        in   1        clock, all logic on rising edge
// nrst       in   1        asynchronous active-low reset
// s_data     in   8        ASCII char
// s_valid    in   1        s_data valid
// s_ready    out  1        char accepted when s_valid & s_ready
// m_data     out  W        parsed value, right-aligned, zero-extended
// m_ndigits  out  $clog2(DIGITS+1)  digits captured (prefix excluded)
// m_err      out  1        token had invalid char, overflow or empty "0x"
// m_valid    out  1        output word valid
// m_ready    in   1        output consumed when m_valid & m_ready
//
// BEHAVIOUR
// - Reset: state=IDLE, acc=0, cnt=0, err=0, m_valid=0, m_data=0,
//   m_ndigits=0, m_err=0. Async assert at any time aborts token, drops output.
// - s_ready = !m_valid | m_ready (single output register, 1 char/cycle).
// - Char classes: digit '0'-'9','A'-'F'(,'a'-'f'); delimiter = 0x20,0x09,
//   0x0D,0x0A,0x2C; anything else invalid.
// - States: IDLE, ACCUM, SKIP.
//   IDLE : delimiter -> consumed, no output. digit -> acc=nib, cnt=1, ACCUM.
//          invalid -> err=1, SKIP.
//   ACCUM: digit, cnt<DIGITS -> acc={acc[W-5:0],nib}, cnt+1.
//          digit, cnt==DIGITS -> err=1, SKIP (acc keeps first DIGITS digits).
//          'x'/'X' with ALLOW_PREFIX, cnt==1, acc==0, no prefix yet ->
//          cnt=0, pfx=1 (stay ACCUM). Second prefix or other invalid -> SKIP.
//          delimiter -> emit, IDLE.
//   SKIP : non-delimiter consumed, dropped. delimiter -> emit, IDLE.
// - Emit: on delimiter-accept cycle register m_data=acc, m_ndigits=cnt,
//   m_err=err|(pfx&cnt==0); m_valid=1 next cycle (latency 1 from delimiter).
//   acc/cnt/err/pfx cleared same edge. m_valid held until m_ready.
// - Simultaneous m_ready & new delimiter: old word retires, new word loads
//   same edge; m_valid stays 1, no bubble.
// - m_data/m_ndigits/m_err stable while m_valid & !m_ready.
// - Consecutive delimiters produce no empty tokens. Tokens never split.
//
// STRUCTURE
// - Package ascii_pkg: delimiter constants, char-class enum
//   {CH_DIGIT, CH_DELIM, CH_PREFIX, CH_INVALID}, parser state enum.
// - Sub-module ascii_hex_classify (combinational): 8-bit char ->
//   {class, 4-bit nibble}, ALLOW_LOWER parameter; instantiated once.
// - Top: FSM, W-bit shift accumulator, counter, output register.
//
// TESTING
// - "1A2f\n", DIGITS=8 -> one word m_data=0x00001A2F, m_ndigits=4, m_err=0.
// - "0x00FF " -> m_data=0xFF, m_ndigits=4, m_err=0; "0x," -> m_data=0,
//   m_ndigits=0, m_err=1; ALLOW_PREFIX=0: "0x12 " -> m_err=1.
// - DIGITS=4, "12345 " -> m_data=0x1234, m_ndigits=4, m_err=1; next "7 " clean.
// - "1G2," -> m_err=1; "  \r\n,," -> no m_valid pulse; ALLOW_LOWER=0
//   "ab " -> m_err=1.
// - Backpressure: m_ready=0 after "12 34 " -> first word held stable,
//   s_ready=0 once second delimiter pending; m_ready=1 -> 0x12 then 0x34 in
//   order, none lost/duplicated; random s_valid/m_ready vs model, 10k chars.
// - nrst low mid-token "AB" then "C " -> outputs zero during reset, single
//   word 0xC, m_ndigits=1 afterwards.

Source files
------------

// File: rtl/ascii_pkg.sv
// ascii_pkg: shared definitions for the ASCII hex parser.
//   - delimiter character codes and a delimiter test helper
//   - character class enum produced by the classifier
//   - parser FSM state enum
package ascii_pkg;

  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  typedef enum logic [1:0] {
    CH_DIGIT   = 2'd0,
    CH_DELIM   = 2'd1,
    CH_PREFIX  = 2'd2,
    CH_INVALID = 2'd3
  } char_class_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SKIP  = 2'd2
  } parse_state_e;

  // True for the token-separating whitespace/comma characters.
  function automatic logic is_delim(input logic [7:0] c);
    logic r;
    case (c)
      CH_SP, CH_TAB, CH_CR, CH_LF, CH_COMMA: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ascii_hex_classify.sv
// ascii_hex_classify: purely combinational character classifier.
//   ch  (in,  8) ASCII character
//   cls (out, 2) CH_DIGIT / CH_DELIM / CH_PREFIX ('x','X') / CH_INVALID
//   nib (out, 4) hex value of the character when cls == CH_DIGIT, else 0
// ALLOW_LOWER=0 makes 'a'..'f' fall into CH_INVALID.
module ascii_hex_classify
  import ascii_pkg::*;
#(
  parameter bit ALLOW_LOWER = 1'b1
) (
  input  logic [7:0]  ch,
  output char_class_e cls,
  output logic [3:0]  nib
);

  // Map one character to its class and nibble value.
  always_comb begin
    cls = CH_INVALID;
    nib = 4'h0;
    if (is_delim(ch)) begin
      cls = CH_DELIM;
    end else if (ch >= 8'h30 && ch <= 8'h39) begin
      cls = CH_DIGIT;
      nib = ch[3:0];
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      // 'A' = 0x41: low nibble 1 maps to value 10
      cls = CH_DIGIT;
      nib = ch[3:0] + 4'd9;
    end else if (ALLOW_LOWER && ch >= 8'h61 && ch <= 8'h66) begin
      cls = CH_DIGIT;
      nib = ch[3:0] + 4'd9;
    end else if (ch == 8'h78 || ch == 8'h58) begin
      cls = CH_PREFIX;
    end else begin
      cls = CH_INVALID;
      nib = 4'h0;
    end
  end

endmodule

// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser: streaming ASCII hex text to binary word converter.
// One character per cycle is accepted over s_valid/s_ready; hex digits are
// shifted in MSB-first and every delimiter that closes a token emits one word.
//   clk, nrst            clock (rising edge), asynchronous active-low reset
//   s_data/s_valid/s_ready   character input stream
//   m_data    (W)        parsed value, right-aligned
//   m_ndigits            digits captured, "0x" prefix excluded
//   m_err                invalid char, overflow or bare "0x" in the token
//   m_valid/m_ready      output word handshake
module ascii_hex_parser
  import ascii_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter bit ALLOW_PREFIX = 1'b1,
  parameter bit ALLOW_LOWER  = 1'b1,
  localparam int W  = 4 * DIGITS,
  localparam int NW = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [W-1:0]  m_data,
  output logic [NW-1:0] m_ndigits,
  output logic          m_err,
  output logic          m_valid,
  input  logic          m_ready
);

  localparam logic [NW-1:0] CNT_MAX = DIGITS[NW-1:0];
  localparam logic [NW-1:0] CNT_ONE = NW'(1);

  parse_state_e  state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          pfx_q, pfx_d;
  logic          m_valid_q, m_valid_d;
  logic [W-1:0]  m_data_q, m_data_d;
  logic [NW-1:0] m_ndigits_q, m_ndigits_d;
  logic          m_err_q, m_err_d;

  char_class_e   cls;
  logic [3:0]    nib;
  logic          accept;
  logic          emit;

  ascii_hex_classify #(
    .ALLOW_LOWER(ALLOW_LOWER)
  ) u_classify (
    .ch  (s_data),
    .cls (cls),
    .nib (nib)
  );

  // The single output register frees up in the same cycle it is consumed,
  // so a new word can load while the old one retires.
  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  // Token FSM: next state, accumulator, digit counter, error and prefix flags.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pfx_d   = pfx_q;
    emit    = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          case (cls)
            CH_DELIM: begin
              state_d = IDLE;
            end
            CH_DIGIT: begin
              acc_d   = {{(W-4){1'b0}}, nib};
              cnt_d   = CNT_ONE;
              state_d = ACCUM;
            end
            default: begin
              err_d   = 1'b1;
              state_d = SKIP;
            end
          endcase
        end
        ACCUM: begin
          case (cls)
            CH_DIGIT: begin
              if (cnt_q < CNT_MAX) begin
                acc_d = {acc_q[W-5:0], nib};
                cnt_d = cnt_q + CNT_ONE;
              end else begin
                // overflow: keep the first DIGITS digits, discard the rest
                err_d   = 1'b1;
                state_d = SKIP;
              end
            end
            CH_PREFIX: begin
              // only a lone leading '0' can turn into a "0x" prefix, once
              if (ALLOW_PREFIX && cnt_q == CNT_ONE && acc_q == '0 && !pfx_q) begin
                cnt_d = '0;
                pfx_d = 1'b1;
              end else begin
                err_d   = 1'b1;
                state_d = SKIP;
              end
            end
            CH_DELIM: begin
              emit    = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              err_d   = 1'b0;
              pfx_d   = 1'b0;
              state_d = IDLE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = SKIP;
            end
          endcase
        end
        SKIP: begin
          if (cls == CH_DELIM) begin
            emit    = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            pfx_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = SKIP;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output word register: load on emit, drop valid once consumed.
  always_comb begin
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_ndigits_d = m_ndigits_q;
    m_err_d     = m_err_q;
    if (emit) begin
      m_valid_d   = 1'b1;
      m_data_d    = acc_q;
      m_ndigits_d = cnt_q;
      m_err_d     = err_q || (pfx_q && cnt_q == '0);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      pfx_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_ndigits_q <= '0;
      m_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      pfx_q       <= pfx_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_ndigits_q <= m_ndigits_d;
      m_err_q     <= m_err_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_ndigits = m_ndigits_q;
  assign m_err     = m_err_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Bench for ascii_hex_parser. Two instances share one stimulus stream:
// u_dut (DIGITS=8, prefix and lowercase allowed) and u_alt (DIGITS=4, no
// prefix, no lowercase). Expected words come from a token-level model that
// splits the text at delimiters and evaluates each token by the parsing rules.
module tb_ascii_hex_parser;

  typedef struct {
    logic [31:0] data;
    logic [31:0] nd;
    logic        err;
  } word_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        m_ready;
  logic        s_ready, m_valid, m_err;
  logic [31:0] m_data;
  logic [3:0]  m_nd;
  logic        a_s_ready, a_m_valid, a_m_err;
  logic [15:0] a_m_data;
  logic [2:0]  a_m_nd;

  int    total = 0;
  int    bad   = 0;
  int    words = 0;
  word_t q_main[$];
  word_t q_alt[$];
  word_t last_main, last_alt;
  logic [7:0] stim[$];
  logic [7:0] tok[$];
  logic  mv_m;

  always #5 clk = ~clk;

  ascii_hex_parser #(.DIGITS(8), .ALLOW_PREFIX(1'b1), .ALLOW_LOWER(1'b1)) u_dut (
    .clk(clk), .nrst(nrst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_ndigits(m_nd), .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready)
  );

  ascii_hex_parser #(.DIGITS(4), .ALLOW_PREFIX(1'b0), .ALLOW_LOWER(1'b0)) u_alt (
    .clk(clk), .nrst(nrst), .s_data(s_data), .s_valid(s_valid), .s_ready(a_s_ready),
    .m_data(a_m_data), .m_ndigits(a_m_nd), .m_err(a_m_err), .m_valid(a_m_valid), .m_ready(m_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_delim_m(input logic [7:0] c);
    return (c == 8'h20 || c == 8'h09 || c == 8'h0D || c == 8'h0A || c == 8'h2C);
  endfunction

  function automatic int hexval(input logic [7:0] c, input bit al);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (al && c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  // Evaluate one complete token (delimiters excluded).
  function automatic word_t eval_tok(input logic [7:0] t[$], input int digits,
                                     input bit ap, input bit al);
    word_t r;
    int i, nib;
    bit pfx, stop;
    r.data = 32'h0; r.nd = 32'h0; r.err = 1'b0;
    pfx = 1'b0; stop = 1'b0; i = 0;
    if (ap && t.size() >= 2 && t[0] == 8'h30 && (t[1] == 8'h78 || t[1] == 8'h58)) begin
      pfx = 1'b1;
      i = 2;
    end
    while (i < t.size() && !stop) begin
      nib = hexval(t[i], al);
      if (nib < 0 || r.nd == 32'(digits)) begin
        r.err = 1'b1;
        stop = 1'b1;
      end else begin
        r.data = (r.data << 4) | 32'(nib);
        r.nd = r.nd + 32'd1;
      end
      i++;
    end
    if (pfx && r.nd == 32'h0) r.err = 1'b1;
    return r;
  endfunction

  // One clock: check outputs against the model at negedge, advance the model.
  task automatic step();
    bit rdy, acc, dl, emit;
    @(negedge clk);
    rdy = !mv_m || m_ready;
    chk("s_ready", 32'(s_ready), 32'(rdy));
    chk("alt_s_ready", 32'(a_s_ready), 32'(rdy));
    chk("m_valid", 32'(m_valid), 32'(mv_m));
    chk("alt_m_valid", 32'(a_m_valid), 32'(mv_m));
    if (mv_m) begin
      if (q_main.size() == 0 || q_alt.size() == 0) begin
        chk("queue_underflow", 32'(q_main.size() + q_alt.size()), 32'd2);
      end else begin
        chk("m_data", m_data, q_main[0].data);
        chk("m_ndigits", 32'(m_nd), q_main[0].nd);
        chk("m_err", 32'(m_err), 32'(q_main[0].err));
        chk("alt_m_data", 32'(a_m_data), q_alt[0].data);
        chk("alt_m_ndigits", 32'(a_m_nd), q_alt[0].nd);
        chk("alt_m_err", 32'(a_m_err), 32'(q_alt[0].err));
        if (m_ready) begin
          last_main = q_main.pop_front();
          last_alt  = q_alt.pop_front();
          words++;
        end
      end
    end
    acc  = s_valid && rdy;
    dl   = is_delim_m(s_data);
    emit = acc && dl && tok.size() != 0;
    if (emit) begin
      q_main.push_back(eval_tok(tok, 8, 1'b1, 1'b1));
      q_alt.push_back(eval_tok(tok, 4, 1'b0, 1'b0));
    end
    mv_m = emit ? 1'b1 : (m_ready ? 1'b0 : mv_m);
    if (acc) begin
      if (dl) tok.delete();
      else    tok.push_back(s_data);
      void'(stim.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic run(input int budget, input bit rnd);
    int cyc;
    cyc = 0;
    while ((stim.size() != 0 || mv_m) && cyc < budget) begin
      s_valid = (stim.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
      s_data  = (stim.size() != 0) ? stim[0] : 8'h00;
      if (rnd) m_ready = ($urandom_range(0, 2) != 0);
      step();
      cyc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic drained(input string tag);
    chk({tag, "_stim_left"}, 32'(stim.size()), 32'd0);
    chk({tag, "_pending"}, 32'(mv_m), 32'd0);
  endtask

  task automatic expect_last(input string tag, input logic [31:0] d, input int n, input bit e,
                             input logic [31:0] ad, input int an, input bit ae);
    chk({tag, "_data"}, last_main.data, d);
    chk({tag, "_nd"}, last_main.nd, 32'(n));
    chk({tag, "_err"}, 32'(last_main.err), 32'(e));
    chk({tag, "_alt_data"}, last_alt.data, ad);
    chk({tag, "_alt_nd"}, last_alt.nd, 32'(an));
    chk({tag, "_alt_err"}, 32'(last_alt.err), 32'(ae));
  endtask

  task automatic directed(input string s, input string tag, input int nwords);
    int w0;
    w0 = words;
    send(s);
    run(200, 1'b0);
    drained(tag);
    chk({tag, "_words"}, 32'(words - w0), 32'(nwords));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"}, m_data, 32'd0);
    chk({tag, "_m_nd"}, 32'(m_nd), 32'd0);
    chk({tag, "_m_err"}, 32'(m_err), 32'd0);
    chk({tag, "_alt_m_valid"}, 32'(a_m_valid), 32'd0);
    chk({tag, "_alt_m_data"}, 32'(a_m_data), 32'd0);
  endtask

  function automatic logic [7:0] rand_char();
    string hs;
    int    r;
    hs = "0123456789ABCDEF";
    r  = int'($urandom_range(0, 9));
    case (r)
      4:       return 8'h61 + 8'($urandom_range(0, 5));
      5:       return 8'h30;
      6:       return ($urandom_range(0, 1) != 0) ? 8'h78 : 8'h58;
      7:       return 8'($urandom_range(0, 255));
      default: return hs[$urandom_range(0, 15)];
    endcase
  endfunction

  function automatic logic [7:0] rand_delim();
    logic [7:0] dl[5];
    dl = '{8'h20, 8'h09, 8'h0D, 8'h0A, 8'h2C};
    return dl[$urandom_range(0, 4)];
  endfunction

  initial begin
    int w0, n, len;
    nrst = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1; mv_m = 1'b0;
    #12;
    check_zero("reset");
    chk("reset_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    directed("1A2f\n", "basic", 1);
    expect_last("basic", 32'h1A2F, 4, 1'b0, 32'h1A2, 3, 1'b1);
    directed("0x00FF ", "prefix", 1);
    expect_last("prefix", 32'hFF, 4, 1'b0, 32'h0, 1, 1'b1);
    directed("0x12 ", "prefix12", 1);
    expect_last("prefix12", 32'h12, 2, 1'b0, 32'h0, 1, 1'b1);
    directed("0x,", "bare_prefix", 1);
    expect_last("bare_prefix", 32'h0, 0, 1'b1, 32'h0, 1, 1'b1);
    directed("12345 ", "overflow", 1);
    expect_last("overflow", 32'h12345, 5, 1'b0, 32'h1234, 4, 1'b1);
    directed("7 ", "after_ovf", 1);
    expect_last("after_ovf", 32'h7, 1, 1'b0, 32'h7, 1, 1'b0);
    directed("1G2,", "invalid", 1);
    expect_last("invalid", 32'h1, 1, 1'b1, 32'h1, 1, 1'b1);
    directed("  \r\n,,", "delims_only", 0);
    directed("ab ", "lower", 1);
    expect_last("lower", 32'hAB, 2, 1'b0, 32'h0, 0, 1'b1);
    directed("123456789 ", "ovf8", 1);
    expect_last("ovf8", 32'h12345678, 8, 1'b1, 32'h1234, 4, 1'b1);

    // backpressure: first word must sit still while input stalls
    w0 = words;
    m_ready = 1'b0;
    send("12 34 ");
    run(12, 1'b0);
    chk("bp_m_valid", 32'(m_valid), 32'd1);
    chk("bp_s_ready", 32'(s_ready), 32'd0);
    chk("bp_held_data", m_data, 32'h12);
    chk("bp_stim_left", 32'(stim.size()), 32'd3);
    m_ready = 1'b1;
    run(50, 1'b0);
    drained("bp");
    chk("bp_words", 32'(words - w0), 32'd2);
    expect_last("bp_last", 32'h34, 2, 1'b0, 32'h34, 2, 1'b0);

    // asynchronous reset in the middle of a token
    send("AB");
    run(20, 1'b0);
    #2 nrst = 1'b0;
    #1;
    check_zero("mid_reset");
    tok.delete(); q_main.delete(); q_alt.delete(); mv_m = 1'b0;
    @(negedge clk);
    check_zero("mid_reset_hold");
    nrst = 1'b1;
    @(posedge clk);
    #1;
    directed("C ", "post_reset", 1);
    expect_last("post_reset", 32'hC, 1, 1'b0, 32'hC, 1, 1'b0);

    // randomized stream with random valid/ready
    n = 0;
    while (n < 10000) begin
      if ($urandom_range(0, 4) == 0) begin
        send("0x");
        n += 2;
      end
      len = int'($urandom_range(0, 10));
      for (int k = 0; k < len; k++) begin
        stim.push_back(rand_char());
        n++;
      end
      for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
        stim.push_back(rand_delim());
        n++;
      end
    end
    run(70000, 1'b1);
    m_ready = 1'b1;
    run(10, 1'b0);
    drained("random");
    chk("random_queue_empty", 32'(q_main.size() + q_alt.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
